// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared defaults and state encoding for the instruction-fetch stage
package if_stage_pkg;

    // Default datapath width, first fetch address and sequential fetch increment
    localparam int unsigned IF_DEF_WORD_WIDTH = 32;
    localparam int unsigned IF_DEF_RESET_PC   = 0;
    localparam int unsigned IF_DEF_PC_STEP    = 4;

    // Fetch sequencer states: FETCH may issue, WAIT has one request in flight,
    // HOLD parks a response that arrived while decode was frozen
    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_WAIT  = 2'd1,
        IF_HOLD  = 2'd2
    } if_state_e;

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch with single-outstanding imem handshake, freeze and branch redirect
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned            WORD_WIDTH = IF_DEF_WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  RESET_PC   = WORD_WIDTH'(IF_DEF_RESET_PC),
    parameter logic [WORD_WIDTH-1:0]  PC_STEP    = WORD_WIDTH'(IF_DEF_PC_STEP)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  freeze_i,
    input  logic                  branch_taken_i,
    input  logic [WORD_WIDTH-1:0] branch_address_i,
    output logic                  imem_req_o,
    output logic [WORD_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_ready_i,
    input  logic                  imem_rvalid_i,
    input  logic [WORD_WIDTH-1:0] imem_rdata_i,
    output logic [WORD_WIDTH-1:0] pc_o,
    output logic [WORD_WIDTH-1:0] instruction_o,
    output logic                  valid_o
);

    if_state_e             state_q, state_d;
    logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WORD_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                  drop_q, drop_d;
    logic [WORD_WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [WORD_WIDTH-1:0] hold_instr_q, hold_instr_d;
    logic [WORD_WIDTH-1:0] pc_q, pc_d;
    logic [WORD_WIDTH-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    logic                  imem_accept;
    logic                  resp_live;
    logic [WORD_WIDTH-1:0] branch_target;

    // A response that is not tagged for discard is the one decode wants
    assign resp_live     = (state_q == IF_WAIT) && imem_rvalid_i && !drop_q;
    assign branch_target = {branch_address_i[WORD_WIDTH-1:2], 2'b00};

    // Request may be issued from FETCH, or back-to-back from WAIT as the
    // current live response lands; reset, freeze and redirect all suppress it
    always_comb begin
        imem_req_o = rst_i && !branch_taken_i && !freeze_i &&
                     ((state_q == IF_FETCH) || resp_live);
    end

    assign imem_accept = imem_req_o && imem_ready_i;
    assign imem_addr_o = fetch_pc_q;

    // Next-state computation for sequencer, fetch address, hold buffer and outputs
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        valid_d      = valid_q;

        if (imem_accept) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (branch_taken_i) begin
            // Redirect wins over freeze and every other event in this cycle
            fetch_pc_d   = branch_target;
            valid_d      = 1'b0;
            instr_d      = '0;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            drop_d       = 1'b0;
            state_d      = IF_FETCH;
            if ((state_q == IF_WAIT) && !imem_rvalid_i) begin
                // Old-path response still to come: tag it for discard
                drop_d  = 1'b1;
                state_d = IF_WAIT;
            end
        end else begin
            // Default when not frozen is a bubble with pc held
            if (!freeze_i) begin
                valid_d = 1'b0;
                instr_d = '0;
            end

            case (state_q)
                IF_FETCH: begin
                    if (imem_accept) begin
                        state_d = IF_WAIT;
                    end
                end
                IF_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = imem_accept ? IF_WAIT : IF_FETCH;
                        end else if (!freeze_i) begin
                            pc_d    = req_pc_q + PC_STEP;
                            instr_d = imem_rdata_i;
                            valid_d = 1'b1;
                            state_d = imem_accept ? IF_WAIT : IF_FETCH;
                        end else begin
                            hold_pc_d    = req_pc_q + PC_STEP;
                            hold_instr_d = imem_rdata_i;
                            state_d      = IF_HOLD;
                        end
                    end
                end
                IF_HOLD: begin
                    if (!freeze_i) begin
                        pc_d    = hold_pc_q;
                        instr_d = hold_instr_q;
                        valid_d = 1'b1;
                        state_d = IF_FETCH;
                    end
                end
                default: begin
                    state_d = IF_FETCH;
                end
            endcase
        end
    end

    // Fetch sequencer state and discard tag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IF_FETCH;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Fetch address and address of the request currently in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    // Hold buffer for a response captured during freeze
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
        end else begin
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // IF/ID output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o          = pc_q;
    assign instruction_o = instr_q;
    assign valid_o       = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - randomized self-checking bench for if_stage against a transaction-level model
module tb_if_stage;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        freeze_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_address_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        valid_o;

    if_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .freeze_i         (freeze_i),
        .branch_taken_i   (branch_taken_i),
        .branch_address_i (branch_address_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .pc_o             (pc_o),
        .instruction_o    (instruction_o),
        .valid_o          (valid_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Model: fetch stream, one outstanding request tagged stale after a redirect,
    // one pending instruction parked while decode is frozen, expected IF/ID regs
    logic [31:0] m_next_addr;
    bit          m_out;
    bit          m_stale;
    logic [31:0] m_out_addr;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_pend_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_valid;

    // Memory: single outstanding, latency 1..max_lat cycles
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic model_reset();
        m_next_addr  = 32'h0;
        m_out        = 0;
        m_stale      = 0;
        m_out_addr   = '0;
        m_pend       = 0;
        m_pend_pc    = '0;
        m_pend_instr = '0;
        exp_pc       = '0;
        exp_instr    = '0;
        exp_valid    = 1'b0;
        mem_busy     = 0;
        mem_cnt      = 0;
        mem_addr     = '0;
    endtask

    task automatic apply_reset();
        rst_i          = 1'b0;
        freeze_i       = 1'b0;
        branch_taken_i = 1'b0;
        imem_ready_i   = 1'b0;
        imem_rvalid_i  = 1'b0;
        #1;
        check_eq("rst_valid", {31'b0, valid_o}, 32'h0);
        check_eq("rst_pc", pc_o, 32'h0);
        check_eq("rst_instr", instruction_o, 32'h0);
        check_eq("rst_req", {31'b0, imem_req_o}, 32'h0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic do_cycle(input int p_frz, input int p_br, input int p_rdy, input int max_lat);
        bit rv;
        bit exp_req;
        bit acc_m;
        bit acc_d;
        @(negedge clk_i);
        check_eq("valid", {31'b0, valid_o}, {31'b0, exp_valid});
        check_eq("pc", pc_o, exp_pc);
        check_eq("instr", instruction_o, exp_instr);

        freeze_i         = ($urandom_range(99) < p_frz);
        branch_taken_i   = ($urandom_range(99) < p_br);
        branch_address_i = $urandom & 32'h0000_FFFF;
        imem_ready_i     = ($urandom_range(99) < p_rdy);
        rv               = mem_busy && (mem_cnt == 0);
        imem_rvalid_i    = rv;
        imem_rdata_i     = rv ? mem_data(mem_addr) : $urandom;
        #1;

        exp_req = rst_i && !branch_taken_i && !freeze_i && !m_pend &&
                  (!m_out || (rv && !m_stale));
        check_eq("imem_req", {31'b0, imem_req_o}, {31'b0, exp_req});
        if (exp_req) check_eq("imem_addr", imem_addr_o, m_next_addr);
        acc_m = exp_req && imem_ready_i;
        acc_d = imem_req_o && imem_ready_i;

        if (branch_taken_i) begin
            m_next_addr = branch_address_i & ~32'h3;
            exp_valid   = 1'b0;
            exp_instr   = '0;
            m_pend      = 0;
            if (m_out) begin
                if (rv) m_out = 0;
                else    m_stale = 1;
            end
        end else begin
            if (m_pend) begin
                if (!freeze_i) begin
                    exp_pc    = m_pend_pc;
                    exp_instr = m_pend_instr;
                    exp_valid = 1'b1;
                    m_pend    = 0;
                end
            end else if (m_out && rv && !m_stale) begin
                m_out = 0;
                if (freeze_i) begin
                    m_pend       = 1;
                    m_pend_pc    = m_out_addr + 32'd4;
                    m_pend_instr = imem_rdata_i;
                end else begin
                    exp_pc    = m_out_addr + 32'd4;
                    exp_instr = imem_rdata_i;
                    exp_valid = 1'b1;
                end
            end else begin
                if (m_out && rv) begin
                    m_out   = 0;
                    m_stale = 0;
                end
                if (!freeze_i) begin
                    exp_valid = 1'b0;
                    exp_instr = '0;
                end
            end
            if (acc_m) begin
                m_out       = 1;
                m_stale     = 0;
                m_out_addr  = m_next_addr;
                m_next_addr = m_next_addr + 32'd4;
            end
        end

        if (rv) mem_busy = 0;
        else if (mem_busy) mem_cnt--;
        if (acc_d) begin
            mem_busy = 1;
            mem_cnt  = $urandom_range(max_lat - 1);
            mem_addr = imem_addr_o;
        end
    endtask

    initial begin
        model_reset();
        apply_reset();

        repeat (40) do_cycle(0, 0, 100, 1);
        repeat (60) do_cycle(0, 0, 50, 3);
        repeat (60) do_cycle(30, 0, 100, 1);
        repeat (80) do_cycle(15, 8, 70, 3);
        repeat (80) do_cycle(25, 15, 60, 2);

        // Drive into WAIT, then pull reset asynchronously between edges
        for (int i = 0; i < 50 && !m_out; i++) do_cycle(0, 0, 100, 3);
        check_eq("wait_reached", {31'b0, m_out}, 32'h1);
        @(posedge clk_i);
        #2;
        apply_reset();

        repeat (120) do_cycle(20, 10, 60, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage. Owns the fetch PC and drives a single-outstanding-request instruction-memory handshake. Delivers {pc, instruction, valid} to the IF/ID pipeline register, which feeds the decode stage's pc_in/instruction_in.
Handles hazard freeze from the hazard unit and branch redirect from EX (branch_taken/branch_address).

Parameters:
WORD_WIDTH, 32, data/address width (shared `WORD_WIDTH from settings.h)
RESET_PC, 0, first fetch address after reset
PC_STEP, 4, fetch address increment in bytes

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-low reset
freeze  in  1  hazard stall; holds outputs, blocks new requests
branch_taken  in  1  one-cycle redirect pulse from EX
branch_address  in  WORD_WIDTH  redirect target; bits [1:0] ignored (forced 0)
imem_req  out  1  fetch request valid
imem_addr  out  WORD_WIDTH  fetch address, equals fetch_pc
imem_ready  in  1  memory accepts request when imem_req && imem_ready
imem_rvalid  in  1  response valid, one per accepted request, any latency >= 1 cycle
imem_rdata  in  WORD_WIDTH  fetched instruction
pc  out  WORD_WIDTH  address of delivered instruction + PC_STEP
instruction  out  WORD_WIDTH  delivered instruction; 0 (team NOP) when bubble
valid  out  1  instruction/pc meaningful this cycle

Behaviour:
- Reset (rst=0, async): fetch_pc=RESET_PC; state=FETCH; drop=0; hold buffer empty; pc=0, instruction=0, valid=0; imem_req=0 while in reset.
- Registered state: fetch_pc, req_pc (address of in-flight request), drop flag, state {FETCH, WAIT, HOLD}, hold buffer {pc, instr}, output regs.
- imem_req (combinational) = !branch_taken && !freeze && (state==FETCH || (state==WAIT && imem_rvalid && !drop)).
- Issue: on imem_req && imem_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^WORD_WIDTH, wraps silently), state<=WAIT.
- FETCH: without an accepted request, state stays FETCH.
- WAIT, imem_rvalid && drop: discard data, drop<=0. Next state is WAIT if a request is accepted the same cycle, else FETCH.
- WAIT, imem_rvalid && !drop && !freeze: pc<=req_pc+PC_STEP, instruction<=imem_rdata, valid<=1. Stay WAIT if a new request is accepted, else FETCH.
- WAIT, imem_rvalid && !drop && freeze: capture into hold buffer; state<=HOLD; outputs unchanged.
- HOLD: no requests issued. When freeze=0: outputs<=hold buffer, valid<=1, state<=FETCH.
- Output update rule: freeze=1 -> pc/instruction/valid hold. freeze=0 with no instruction delivered -> valid<=0, instruction<=0, pc holds.
- Branch priority: branch_taken overrides freeze and every other event:
  - fetch_pc<={branch_address[WORD_WIDTH-1:2],2'b00}; valid<=0; instruction<=0; hold buffer cleared.
  - WAIT with no rvalid that cycle: drop<=1, stay WAIT.
  - WAIT with rvalid that cycle: response discarded, state<=FETCH.
  - HOLD or FETCH: state<=FETCH.
  - No request is issued in the branch cycle.
- Throughput: 1 instruction/cycle with 1-cycle-latency memory and imem_ready=1. Redirect penalty: first target instruction valid 2 cycles after the branch cycle (1-cycle memory).
- imem_ready=0: request stays asserted with stable imem_addr until accepted, unless freeze or branch intervenes.
- Reset mid-operation: all state cleared. A response arriving after reset release without a post-reset request is a memory protocol violation; the memory is reset by the same rst.

Decomposition:
- settings.h: `WORD_WIDTH, `RESET_PC, `PC_STEP, and 2-bit state encoding constants (IF_FETCH=0, IF_WAIT=1, IF_HOLD=2).
- No sub-module required. fetch_pc and output registers are plain always blocks with async active-low reset.

Test Plan:
- Reset then release, imem_ready=1, 1-cycle memory returning addr as data -> imem_addr 0,4,8,...; outputs (pc,instr) = (4,0),(8,4),(12,8), valid=1 every cycle from cycle 2.
- 3-cycle memory latency, imem_ready toggling -> one outstanding request only; imem_addr stable while !imem_ready; valid pulses once per response with correct pc.
- freeze=1 for 4 cycles while response to addr 8 in flight -> state HOLD, outputs frozen at (8,4), no imem_req; on release outputs become (12,8) next cycle.
- branch_taken with branch_address=0x103 while WAIT on addr 0x20 -> that response discarded (drop), next imem_addr=0x100, first delivered pc=0x104, valid=0 in between.
- branch_taken in the same cycle as imem_rvalid and freeze=1 -> data discarded, valid=0, instruction=0, next request to target the following cycle.
- Assert rst=0 mid-WAIT asynchronously -> valid, pc, instruction, imem_req drop to 0 immediately; after release, fetch restarts at RESET_PC.
